// File: rtl/icache_arb_pkg.sv
// Shared constants for the icache bank arbiter: FSM state encoding and stall-counter width.
package icache_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;

  localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index converter; an all-zero input yields index 0.
module onehot_to_bin #(
  parameter int unsigned ONEHOT_WIDTH = 4,
  localparam int unsigned BIN_WIDTH = (ONEHOT_WIDTH > 1) ? $clog2(ONEHOT_WIDTH) : 1
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot,
  output logic [BIN_WIDTH-1:0]    bin
);

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
      if (onehot[i]) begin
        bin = bin | BIN_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/icache_bank_arbiter.sv
// Round-robin arbiter sharing one icache SCM bank between N_REQ fetch ports, one transaction
// in flight. Define ICACHE_ARB_STATS_EN to add per-requester saturating stall counters.
module icache_bank_arbiter
  import icache_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned ID_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic [N_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic                        bank_req_o,
  output logic [ADDR_WIDTH-1:0]       bank_addr_o,
  output logic [ID_WIDTH-1:0]         bank_id_o,
  input  logic                        bank_gnt_i,
  input  logic                        bank_rvalid_i,
  input  logic [DATA_WIDTH-1:0]       bank_rdata_i
`ifdef ICACHE_ARB_STATS_EN
  ,
  input  logic                        stats_clr_i,
  output logic [N_REQ*STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [N_REQ-1:0]      prio_mask, masked_req, win_oh, owner_oh;
  logic [ID_WIDTH-1:0]   win_id, ptr_inc;
  logic [ADDR_WIDTH-1:0] win_addr;

  // Requests at or above rr_ptr take priority; fall back to the plain request vector on wrap.
  always_comb begin
    prio_mask = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      prio_mask[k] = (k >= 32'(rr_ptr_q));
    end
    masked_req = req_i & prio_mask;
    if (|masked_req) begin
      win_oh = masked_req & (~masked_req + N_REQ'(1));
    end else begin
      win_oh = req_i & (~req_i + N_REQ'(1));
    end
  end

  onehot_to_bin #(
    .ONEHOT_WIDTH (N_REQ)
  ) u_win_bin (
    .onehot (win_oh),
    .bin    (win_id)
  );

  always_comb begin
    win_addr = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_oh[k]) begin
        win_addr = win_addr | addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign ptr_inc  = (owner_q == ID_WIDTH'(N_REQ - 1)) ? '0 : owner_q + ID_WIDTH'(1);
  assign owner_oh = N_REQ'(1) << owner_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = ISSUE;
          owner_d = win_id;
          addr_d  = win_addr;
        end
      end
      ISSUE: begin
        if (bank_gnt_i) begin
          state_d  = WAIT_R;
          rr_ptr_d = ptr_inc;
        end
      end
      WAIT_R: begin
        if (bank_rvalid_i) begin
          // Re-arbitrate on the response cycle to keep back-to-back fetches at 2 cycles each.
          if (|req_i) begin
            state_d = ISSUE;
            owner_d = win_id;
            addr_d  = win_addr;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
    end
  end

  assign bank_req_o  = (state_q == ISSUE);
  assign bank_addr_o = addr_q;
  assign bank_id_o   = owner_q;
  assign gnt_o       = ((state_q == ISSUE) && bank_gnt_i) ? owner_oh : '0;
  assign rvalid_o    = ((state_q == WAIT_R) && bank_rvalid_i) ? owner_oh : '0;
  assign rdata_o     = (|rvalid_o) ? bank_rdata_i : '0;

`ifdef ICACHE_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q [N_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        stall_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (stats_clr_i) begin
          stall_q[k] <= '0;
        end else if (req_i[k] && !gnt_o[k] && (stall_q[k] != '1)) begin
          stall_q[k] <= stall_q[k] + STALL_CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      stall_cnt_o[k*STALL_CNT_W +: STALL_CNT_W] = stall_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_icache_bank_arbiter.sv
// Self-checking bench for icache_bank_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the arbitration rules.
module tb_icache_bank_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_i;
  logic [N*AW-1:0] addr_i;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            bank_req_o;
  logic [AW-1:0]   bank_addr_o;
  logic [1:0]      bank_id_o;
  logic            bank_gnt_i, bank_rvalid_i;
  logic [DW-1:0]   bank_rdata_i;
`ifdef ICACHE_ARB_STATS_EN
  logic            stats_clr_i;
  logic [N*16-1:0] stall_cnt_o;
`endif

  icache_bank_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .bank_req_o    (bank_req_o),
    .bank_addr_o   (bank_addr_o),
    .bank_id_o     (bank_id_o),
    .bank_gnt_i    (bank_gnt_i),
    .bank_rvalid_i (bank_rvalid_i),
    .bank_rdata_i  (bank_rdata_i)
`ifdef ICACHE_ARB_STATS_EN
    ,
    .stats_clr_i   (stats_clr_i),
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: is a fetch in flight, has the bank accepted it, who owns it.
  bit          m_busy, m_granted;
  int          m_owner, m_ptr;
  logic [31:0] m_addr;
  int          m_stall [N];
  logic [N-1:0] seen_gnt;
  int          gnt_log[$];
  int          id_log[$];

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_granted = 0; m_owner = 0; m_ptr = 0; m_addr = '0;
    for (int k = 0; k < N; k++) m_stall[k] = 0;
  endtask

  task automatic model_latch();
    m_owner   = pick(req_i, m_ptr);
    m_addr    = addr_i[m_owner*AW +: AW];
    m_busy    = 1;
    m_granted = 0;
  endtask

  always begin
    logic [N-1:0] e_gnt, e_rv;
    logic         e_req;
    @(negedge clk);
    if (!rst_n) model_reset();
    e_req = m_busy && !m_granted;
    e_gnt = (e_req && bank_gnt_i) ? N'(1 << m_owner) : '0;
    e_rv  = (m_busy && m_granted && bank_rvalid_i) ? N'(1 << m_owner) : '0;
    check("bank_req", 64'(bank_req_o), 64'(e_req));
    check("gnt", 64'(gnt_o), 64'(e_gnt));
    check("rvalid", 64'(rvalid_o), 64'(e_rv));
    check("bank_addr", 64'(bank_addr_o), 64'(m_addr));
    check("bank_id", 64'(bank_id_o), 64'(m_owner));
    if (e_rv != 0) check("rdata", 64'(rdata_o), 64'(bank_rdata_i));
`ifdef ICACHE_ARB_STATS_EN
    for (int k = 0; k < N; k++) check("stall_cnt", 64'(stall_cnt_o[k*16 +: 16]), 64'(m_stall[k]));
`endif
    seen_gnt = gnt_o;
    for (int k = 0; k < N; k++) begin
      if (gnt_o[k]) begin
        gnt_log.push_back(k);
        id_log.push_back(int'(bank_id_o));
      end
    end
    @(posedge clk);
    if (rst_n) begin
`ifdef ICACHE_ARB_STATS_EN
      for (int k = 0; k < N; k++) begin
        if (stats_clr_i) m_stall[k] = 0;
        else if (req_i[k] && !e_gnt[k] && m_stall[k] < 65535) m_stall[k]++;
      end
`endif
      if (!m_busy) begin
        if (req_i != 0) model_latch();
      end else if (!m_granted) begin
        if (bank_gnt_i) begin
          m_granted = 1;
          m_ptr     = (m_owner + 1) % N;
        end
      end else if (bank_rvalid_i) begin
        if (req_i != 0) model_latch();
        else m_busy = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_i = '0; bank_gnt_i = 1'b1; bank_rvalid_i = 1'b1;
    repeat (4) step();
    bank_gnt_i = 1'b0; bank_rvalid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_i = '0; addr_i = '0;
    bank_gnt_i = 1'b0; bank_rvalid_i = 1'b0; bank_rdata_i = '0;
`ifdef ICACHE_ARB_STATS_EN
    stats_clr_i = 1'b0;
`endif
    // Reset state, then an unsolicited bank response in IDLE.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_bank_req", 64'(bank_req_o), 64'h0);
    check("rst_bank_addr", 64'(bank_addr_o), 64'h0);
    check("rst_bank_id", 64'(bank_id_o), 64'h0);
    step(); rst_n = 1'b1; bank_rvalid_i = 1'b1; bank_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("idle_rvalid_ignored", 64'(rvalid_o), 64'h0);
    step(); bank_rvalid_i = 1'b0;

    // All four requesting with a zero-latency bank: strict rotation 0,1,2,3,0.
    gnt_log.delete(); id_log.delete();
    req_i = 4'b1111;
    for (int k = 0; k < N; k++) addr_i[k*AW +: AW] = 32'(k * 'h100);
    bank_gnt_i = 1'b1; bank_rvalid_i = 1'b1;
    repeat (10) step();
    check("rr_count", 64'(gnt_log.size() >= 5), 64'h1);
    if (gnt_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("rr_order", 64'(gnt_log[i]), 64'(i % 4));
        check("rr_id", 64'(id_log[i]), 64'(i % 4));
      end
    end
    drain();

    // Single requester 2 with a bank that stalls its grant for three cycles.
    step(); req_i = 4'b0100; addr_i[2*AW +: AW] = 32'h40;
    @(negedge clk);
    check("t3_no_req_same_cycle", 64'(bank_req_o), 64'h0);
    step();
    @(negedge clk);
    check("t3_bank_req", 64'(bank_req_o), 64'h1);
    check("t3_bank_addr", 64'(bank_addr_o), 64'h40);
    check("t3_bank_id", 64'(bank_id_o), 64'h2);
    check("t3_no_gnt", 64'(gnt_o), 64'h0);
    step(); step();
    @(negedge clk);
    check("t3_still_no_gnt", 64'(gnt_o), 64'h0);
    step(); bank_gnt_i = 1'b1;
    @(negedge clk);
    check("t3_gnt", 64'(gnt_o), 64'b0100);
    step(); bank_gnt_i = 1'b0; req_i = '0; bank_rvalid_i = 1'b1; bank_rdata_i = 32'h1234_5678;
    @(negedge clk);
    check("t3_rvalid", 64'(rvalid_o), 64'b0100);
    check("t3_rdata", 64'(rdata_o), 64'h1234_5678);
    step(); bank_rvalid_i = 1'b0;
    @(negedge clk);
    check("t3_back_to_idle", 64'(bank_req_o), 64'h0);

    // Owner 3 completes while 0 and 3 request: pointer wraps, 0 goes straight to ISSUE.
    step(); req_i = 4'b1000; addr_i[3*AW +: AW] = 32'h300;
    step(); bank_gnt_i = 1'b1;
    @(negedge clk);
    check("t4_gnt3", 64'(gnt_o), 64'b1000);
    step(); bank_gnt_i = 1'b0; req_i = 4'b1001; addr_i[0 +: AW] = 32'h500; bank_rvalid_i = 1'b1;
    @(negedge clk);
    check("t4_rvalid3", 64'(rvalid_o), 64'b1000);
    step(); bank_rvalid_i = 1'b0;
    @(negedge clk);
    check("t4_wrap_issue", 64'(bank_req_o), 64'h1);
    check("t4_wrap_id", 64'(bank_id_o), 64'h0);
    check("t4_wrap_addr", 64'(bank_addr_o), 64'h500);
    drain();

    // Reset while waiting for a response; the late response must vanish, rr_ptr back to 0.
    step(); req_i = 4'b0010; addr_i[AW +: AW] = 32'h10;
    step(); bank_gnt_i = 1'b1;
    step(); bank_gnt_i = 1'b0; req_i = '0; rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_bank_req", 64'(bank_req_o), 64'h0);
    check("t5_rst_addr", 64'(bank_addr_o), 64'h0);
    step(); rst_n = 1'b1; bank_rvalid_i = 1'b1;
    @(negedge clk);
    check("t5_stale_rvalid", 64'(rvalid_o), 64'h0);
    step(); bank_rvalid_i = 1'b0; req_i = 4'b1111;
    step();
    @(negedge clk);
    check("t5_ptr_zero", 64'(bank_id_o), 64'h0);
    drain();

`ifdef ICACHE_ARB_STATS_EN
    // Requester 1 waits five cycles for its grant.
    step(); stats_clr_i = 1'b1;
    step(); stats_clr_i = 1'b0; req_i = 4'b0010;
    repeat (5) step();
    bank_gnt_i = 1'b1;
    @(negedge clk);
    check("t6_stall5", 64'(stall_cnt_o[16 +: 16]), 64'd5);
    step(); bank_gnt_i = 1'b0; req_i = '0; stats_clr_i = 1'b1;
    step(); stats_clr_i = 1'b0;
    @(negedge clk);
    check("t6_cleared", 64'(stall_cnt_o), 64'h0);
    drain();
`endif

    // Randomized traffic; requesters hold req and addr until they see their grant.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      rst_n = ($urandom_range(0, 499) != 0);
      for (int k = 0; k < N; k++) begin
        if (req_i[k] && seen_gnt[k]) begin
          req_i[k] = ($urandom_range(0, 3) == 0);
          addr_i[k*AW +: AW] = $urandom;
        end else if (!req_i[k] && $urandom_range(0, 2) == 0) begin
          req_i[k] = 1'b1;
          addr_i[k*AW +: AW] = $urandom;
        end
      end
      bank_gnt_i    = $urandom_range(0, 1) == 1;
      bank_rvalid_i = $urandom_range(0, 2) == 0;
      bank_rdata_i  = $urandom;
`ifdef ICACHE_ARB_STATS_EN
      stats_clr_i = ($urandom_range(0, 99) == 0);
`endif
    end
    rst_n = 1'b1;
    drain();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
